dram_frame_packer: RTL



---
 rtl/dram_frame_packer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dram_frame_packer.sv
// dram_frame_packer: packs 8-bit pixels into 64-bit words and issues per-frame descriptors.
// Optional macro PACKER_PAD_EN: zero-pad short frames up to the described byte count.
module dram_frame_packer #(
    parameter int unsigned NUM_BUFS   = 2,
    parameter logic [31:0] BUF_STRIDE = 32'h0020_0000
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_base_addr,
    input  logic [31:0] cfg_frame_bytes,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_last,
    output logic        wr_frame_valid,
    input  logic        wr_frame_ready,
    output logic [31:0] wr_BUF_ADDR,
    output logic [31:0] wr_FRAME_BYTES,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [1:0]  buf_idx,
    output logic [15:0] frame_count,
    output logic        err_short,
    output logic        err_long
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_PACK,
        S_FLUSH,
        S_DRAIN
`ifdef PACKER_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t      state, next_state;
    logic [31:0] fb_q, bcnt;
    logic [63:0] acc;
    logic [2:0]  lane;
    logic        start, pack_take, pack_load, pad_load;
    logic        complete, set_short, set_long;
    logic        slot_free, full_next;
    logic [31:0] fb_cfg, bcnt_next, buf_off;
    logic [63:0] word;
    logic        unused_ok;

    assign unused_ok = ^cfg_frame_bytes[6:0];
    assign fb_cfg    = {cfg_frame_bytes[31:7], 7'b0};
    assign slot_free = !dout_valid || dout_ready;
    assign bcnt_next = bcnt + 32'd8;
    assign full_next = (bcnt_next == fb_q);
    assign buf_off   = {30'b0, buf_idx} * BUF_STRIDE;
    // Lanes above the current one are still zero, so a mid-word last is zero-filled
    assign word      = acc | ({56'b0, pix_data} << {lane, 3'b000});
    assign wr_frame_valid = (state == S_DESC);

    always_ff @(posedge fclk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        pix_ready  = 1'b0;
        start      = 1'b0;
        pack_take  = 1'b0;
        pack_load  = 1'b0;
        pad_load   = 1'b0;
        complete   = 1'b0;
        set_short  = 1'b0;
        set_long   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_enable && fb_cfg != 32'd0) begin
                    start      = 1'b1;
                    next_state = S_DESC;
                end
            end
            S_DESC: begin
                if (wr_frame_ready) next_state = S_PACK;
            end
            S_PACK: begin
                pix_ready = slot_free;
                if (pix_valid && slot_free) begin
                    if (lane == 3'd7 || pix_last) begin
                        pack_load = 1'b1;
                        if (full_next) begin
                            if (pix_last) begin
                                next_state = S_DRAIN;
                            end else begin
                                set_long   = 1'b1;
                                next_state = S_FLUSH;
                            end
                        end else if (pix_last) begin
                            set_short  = 1'b1;
`ifdef PACKER_PAD_EN
                            next_state = S_PAD;
`else
                            next_state = S_DRAIN;
`endif
                        end
                    end else begin
                        pack_take = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_last) next_state = S_DRAIN;
            end
`ifdef PACKER_PAD_EN
            S_PAD: begin
                if (slot_free) begin
                    pad_load = 1'b1;
                    if (full_next) next_state = S_DRAIN;
                end
            end
`endif
            S_DRAIN: begin
                // Frame is finished only once its final word has left
                if (slot_free) begin
                    complete   = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            fb_q           <= 32'd0;
            bcnt           <= 32'd0;
            acc            <= 64'd0;
            lane           <= 3'd0;
            wr_BUF_ADDR    <= 32'd0;
            wr_FRAME_BYTES <= 32'd0;
            dout           <= 64'd0;
            dout_valid     <= 1'b0;
            buf_idx        <= 2'd0;
            frame_count    <= 16'd0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
        end else begin
            if (start) begin
                fb_q           <= fb_cfg;
                wr_BUF_ADDR    <= cfg_base_addr + buf_off;
                wr_FRAME_BYTES <= fb_cfg;
                bcnt           <= 32'd0;
                acc            <= 64'd0;
                lane           <= 3'd0;
            end
            if (pack_load) begin
                dout       <= word;
                dout_valid <= 1'b1;
                bcnt       <= bcnt_next;
                acc        <= 64'd0;
                lane       <= 3'd0;
            end else if (pad_load) begin
                dout       <= 64'd0;
                dout_valid <= 1'b1;
                bcnt       <= bcnt_next;
            end else begin
                if (dout_ready) dout_valid <= 1'b0;
                if (pack_take) begin
                    acc[{lane, 3'b000} +: 8] <= pix_data;
                    lane <= lane + 3'd1;
                end
            end
            if (set_short) err_short <= 1'b1;
            if (set_long)  err_long  <= 1'b1;
            if (complete) begin
                frame_count <= frame_count + 16'd1;
                if ({30'b0, buf_idx} == NUM_BUFS - 32'd1) buf_idx <= 2'd0;
                else                                      buf_idx <= buf_idx + 2'd1;
            end
        end
    end
endmodule
